// File: rtl/seg_display_pkg.sv
// Shared constants, segment table and conversion-state encoding for the
// seven-segment score display.
package seg_display_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low {g,f,e,d,c,b,a}, entry n is the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} convState_t;

  function automatic logic [6:0] digitToSeg(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_TABLE[d];
  endfunction
endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, result committed
// atomically, with a single-entry last-wins pending load.
module bin_to_bcd_seq
  import seg_display_pkg::*;
#(
  parameter int VALUE_W   = 14,
  parameter int MAX_VALUE = 9999
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               start,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   result,
  output logic [BCD_W-1:0]   digits
);
  localparam int CNT_W = $clog2(VALUE_W + 1);

  convState_t         state, stateNext;
  logic [CNT_W-1:0]   cnt;
  logic [VALUE_W-1:0] bin, pend;
  logic [BCD_W-1:0]   bcd;
  logic               pendVld, reload;

  function automatic logic [VALUE_W-1:0] saturate(input logic [VALUE_W-1:0] v);
    if (int'(v) > MAX_VALUE) return VALUE_W'(MAX_VALUE);
    return v;
  endfunction

  function automatic logic [BCD_W+VALUE_W-1:0] ddStep(input logic [BCD_W-1:0]   b,
                                                      input logic [VALUE_W-1:0] v);
    logic [BCD_W-1:0] adj;
    adj = b;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    return {adj, v} << 1;
  endfunction

  assign busy   = (state != IDLE);
  assign done   = (state == COMMIT);
  assign result = bcd;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = SHIFT;
      SHIFT:   if (!reload && cnt == CNT_W'(1)) stateNext = COMMIT;
      COMMIT:  stateNext = (pendVld || start) ? SHIFT : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Control: state, pending bookkeeping and the committed digits.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      pendVld <= 1'b0;
      reload  <= 1'b0;
      digits  <= '0;
    end else begin
      state  <= stateNext;
      reload <= (state == COMMIT) && (pendVld || start);
      if (state == COMMIT) digits <= bcd;
      if (busy && start) begin
        pend    <= saturate(value);
        pendVld <= 1'b1;
      end else if (reload) begin
        pendVld <= 1'b0;
      end
    end
  end

  // Datapath: a reload cycle after COMMIT takes the pending value as a fresh start.
  always_ff @(posedge Clock) begin
    case (state)
      IDLE: if (start) begin
        bin <= saturate(value);
        bcd <= '0;
        cnt <= CNT_W'(VALUE_W);
      end
      SHIFT: if (reload) begin
        bin <= pend;
        bcd <= '0;
        cnt <= CNT_W'(VALUE_W);
      end else begin
        {bcd, bin} <= ddStep(bcd, bin);
        cnt        <= cnt - 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/seg_display_scanner.sv
// Four-digit common-anode scanner: converts the score to BCD, blanks leading
// zeros and advances one digit per fastClock pulse.
module seg_display_scanner
  import seg_display_pkg::*;
#(
  parameter int VALUE_W       = 14,
  parameter int MAX_VALUE     = 9999,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  fastClock,
  input  logic [VALUE_W-1:0]    Value,
  input  logic                  ValueValid,
  output logic                  Busy,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);
  logic [BCD_W-1:0]      result, digits, showDigits;
  logic                  done, zeroAbove;
  logic [1:0]            idx, idxNext;
  logic [NUM_DIGITS-1:0] blank;

  bin_to_bcd_seq #(
    .VALUE_W   (VALUE_W),
    .MAX_VALUE (MAX_VALUE)
  ) u_bcd (
    .Clock  (Clock),
    .Reset  (Reset),
    .start  (ValueValid),
    .value  (Value),
    .busy   (Busy),
    .done   (done),
    .result (result),
    .digits (digits)
  );

  // Forwarding the finished accumulator makes a commit visible one cycle after COMMIT.
  assign showDigits = done ? result : digits;
  assign idxNext    = fastClock ? idx + 2'd1 : idx;
  assign dp         = 1'b1;

  always_comb begin
    blank     = '0;
    zeroAbove = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zeroAbove = zeroAbove && (showDigits[4*k +: 4] == 4'd0);
      blank[k]  = (BLANK_LEADING != 0) && zeroAbove;
    end
  end

  // Output register stage.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx <= 2'd0;
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      idx <= idxNext;
      an  <= ~(NUM_DIGITS'(1) << idxNext);
      seg <= blank[idxNext] ? SEG_BLANK : digitToSeg(showDigits[4*idxNext +: 4]);
    end
  end
endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: a schedule-level model checked every cycle
// plus directed literal expectations from the display test plan.
module tb_seg_display_scanner;
  typedef logic [3:0][6:0] pat_t;

  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100,
                         D3 = 7'b0110000, D4 = 7'b0011001, D5 = 7'b0010010,
                         D6 = 7'b0000010, D7 = 7'b1111000, D8 = 7'b0000000,
                         D9 = 7'b0010000, BL = 7'b1111111;

  logic        Clock, Reset, fastClock, ValueValid;
  logic [13:0] Value;
  logic        Busy, dp, Busy0, dp0;
  logic [6:0]  seg, seg0;
  logic [3:0]  an, an0;

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;

  seg_display_scanner #(.VALUE_W(14), .MAX_VALUE(9999), .BLANK_LEADING(1)) dut (
    .Clock(Clock), .Reset(Reset), .fastClock(fastClock), .Value(Value),
    .ValueValid(ValueValid), .Busy(Busy), .seg(seg), .dp(dp), .an(an));

  seg_display_scanner #(.VALUE_W(14), .MAX_VALUE(9999), .BLANK_LEADING(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .fastClock(fastClock), .Value(Value),
    .ValueValid(ValueValid), .Busy(Busy0), .seg(seg0), .dp(dp0), .an(an0));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nChecks++;
    if (act === want) nPass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
  endtask

  // Model: a job started by a strobe at S is busy S+1..S+15 and is shown from S+16;
  // a pending job behaves as a strobe in the cycle after the commit (busy there too).
  bit         mReady = 1'b0;
  bit         mJob, mFromPend, mPend;
  int         mS, mVal, mPendVal, mShown, mIdx;
  logic [3:0] eAn;
  logic [6:0] eSeg, eSeg0;

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [6:0] segOf(input int v, input int k, input bit blankLead);
    int p, d;
    p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
    d = (v / p) % 10;
    if (blankLead && k > 0 && v < p) return BL;
    case (d)
      0: return D0; 1: return D1; 2: return D2; 3: return D3; 4: return D4;
      5: return D5; 6: return D6; 7: return D7; 8: return D8; default: return D9;
    endcase
  endfunction

  function automatic bit busyAt(input int c);
    return mJob && ((c > mS && c <= mS + 15) || (mFromPend && c == mS));
  endfunction

  always @(posedge Clock) begin : model
    int c, disp;
    bit busyNow;
    c = cyc;
    if (Reset) begin
      mReady = 1'b1; mJob = 1'b0; mPend = 1'b0; mFromPend = 1'b0;
      mShown = 0; mIdx = 0;
      eAn = 4'b1111; eSeg = BL; eSeg0 = BL;
    end else if (mReady) begin
      busyNow = busyAt(c);
      disp = mShown;
      if (mJob && c == mS + 15) disp = mVal;
      if (ValueValid) begin
        if (busyNow) begin
          mPend = 1'b1; mPendVal = sat(int'(Value));
        end else begin
          mJob = 1'b1; mS = c; mVal = sat(int'(Value)); mFromPend = 1'b0;
        end
      end
      if (mJob && c == mS + 15) begin
        mShown = mVal;
        mJob = 1'b0;
        if (mPend) begin
          mJob = 1'b1; mS = c + 1; mVal = mPendVal; mPend = 1'b0; mFromPend = 1'b1;
        end
      end
      if (fastClock) mIdx = (mIdx + 1) % 4;
      eAn   = ~(4'b0001 << mIdx);
      eSeg  = segOf(disp, mIdx, 1'b1);
      eSeg0 = segOf(disp, mIdx, 1'b0);
    end
    cyc = cyc + 1;
  end

  always @(negedge Clock) begin
    if (mReady) begin
      chk("busy", {31'd0, Busy}, {31'd0, busyAt(cyc)});
      chk("an", {28'd0, an}, {28'd0, eAn});
      chk("seg", {25'd0, seg}, {25'd0, eSeg});
      chk("dp", {31'd0, dp}, 32'd1);
      chk("busy_noblank", {31'd0, Busy0}, {31'd0, busyAt(cyc)});
      chk("an_noblank", {28'd0, an0}, {28'd0, eAn});
      chk("seg_noblank", {25'd0, seg0}, {25'd0, eSeg0});
      chk("dp_noblank", {31'd0, dp0}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input int v);
    Value = 14'(v);
    ValueValid = 1'b1;
    tick();
    ValueValid = 1'b0;
  endtask

  task automatic pulse();
    fastClock = 1'b1;
    tick();
    fastClock = 1'b0;
  endtask

  // Expects the scan index at 0; walks all four digits and returns to digit 0.
  task automatic showAll(input string name, input pat_t want, input pat_t want0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) pulse();
      chk({name, " an"}, {28'd0, an}, {28'd0, ~(4'b0001 << k)});
      chk({name, " seg"}, {25'd0, seg}, {25'd0, want[k]});
      chk({name, " seg_noblank"}, {25'd0, seg0}, {25'd0, want0[k]});
    end
    pulse();
  endtask

  initial begin
    Reset = 1'b1; fastClock = 1'b0; ValueValid = 1'b0; Value = '0;
    ticks(3);
    chk("reset an", {28'd0, an}, 32'hF);
    chk("reset seg", {25'd0, seg}, {25'd0, BL});
    chk("reset busy", {31'd0, Busy}, 32'd0);
    Reset = 1'b0;
    tick();
    tick();
    chk("first scan an", {28'd0, an}, 32'hE);
    chk("first scan seg", {25'd0, seg}, {25'd0, D0});

    // Eight pulses, no value loaded.
    for (int i = 0; i < 8; i++) begin
      pulse();
      chk("idle scan an", {28'd0, an}, {28'd0, ~(4'b0001 << ((i + 1) % 4))});
      chk("idle scan seg", {25'd0, seg}, {25'd0, (((i + 1) % 4) == 0) ? D0 : BL});
    end

    // 1234: Busy window and digit-by-digit display.
    strobe(1234);
    chk("1234 busy T+1", {31'd0, Busy}, 32'd1);
    ticks(14);
    chk("1234 busy T+15", {31'd0, Busy}, 32'd1);
    tick();
    chk("1234 busy T+16", {31'd0, Busy}, 32'd0);
    chk("model 1234", mShown, 1234);
    showAll("1234", {D1, D2, D3, D4}, {D1, D2, D3, D4});

    strobe(16383);
    ticks(15);
    chk("model saturate", mShown, 9999);
    showAll("16383", {D9, D9, D9, D9}, {D9, D9, D9, D9});

    strobe(0);
    ticks(15);
    showAll("zero", {BL, BL, BL, D0}, {D0, D0, D0, D0});

    strobe(105);
    ticks(15);
    showAll("105", {BL, D1, D0, D5}, {D0, D1, D0, D5});

    // 42 at T, 77 at T+3, 500 at T+5: 77 dropped, 500 shown from T+32.
    strobe(42);
    ticks(2);
    strobe(77);
    tick();
    strobe(500);
    ticks(10);
    chk("multi T+16 digit0", {25'd0, seg}, {25'd0, D2});
    chk("multi T+16 busy", {31'd0, Busy}, 32'd1);
    ticks(15);
    chk("multi T+31 digit0", {25'd0, seg}, {25'd0, D2});
    tick();
    chk("multi T+32 digit0", {25'd0, seg}, {25'd0, D0});
    chk("multi T+32 busy", {31'd0, Busy}, 32'd0);
    chk("model 500", mShown, 500);
    showAll("500", {BL, D5, D0, D0}, {D0, D5, D0, D0});

    // Strobe landing on the COMMIT cycle becomes a pending load.
    strobe(321);
    ticks(14);
    strobe(654);
    chk("commit-strobe T+16 digit0", {25'd0, seg}, {25'd0, D1});
    chk("commit-strobe T+16 busy", {31'd0, Busy}, 32'd1);
    ticks(15);
    chk("commit-strobe T+31 busy", {31'd0, Busy}, 32'd1);
    tick();
    chk("commit-strobe T+32 digit0", {25'd0, seg}, {25'd0, D4});
    showAll("654", {BL, D6, D5, D4}, {D0, D6, D5, D4});

    // Reset in the middle of a 9999 conversion.
    strobe(9999);
    ticks(6);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort busy", {31'd0, Busy}, 32'd0);
    chk("abort an", {28'd0, an}, 32'hF);
    ticks(30);
    chk("abort digit0", {25'd0, seg}, {25'd0, D0});
    chk("model abort", mShown, 0);
    showAll("abort", {BL, BL, BL, D0}, {D0, D0, D0, D0});

    // Scan advancing every cycle across a conversion.
    fastClock = 1'b1;
    strobe(4321);
    ticks(40);
    fastClock = 1'b0;
    ticks(3);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
